// File: rtl/instr_queue_pkg.sv
// Shared issue-stage types and constants for the instruction queue.
package instr_queue_pkg;

    localparam int unsigned INSTR_QUEUE_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } pipe_in_t;

    localparam int unsigned PIPE_IN_W = $bits(pipe_in_t);

endpackage

// File: rtl/instr_queue.sv
// Circular FIFO of decoded entries feeding issue; full drives fetch stall.
// Optional same-cycle empty-queue bypass enabled by macro INSTR_QUEUE_BYPASS_EN.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INSTR_QUEUE_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          enq_valid,
    input  logic [PIPE_IN_W-1:0]          enq_data,
    output logic                          queue_full,
    output logic                          deq_valid,
    output logic [PIPE_IN_W-1:0]          deq_data,
    input  logic                          deq_ready,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PIPE_IN_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic                 not_empty;
    logic                 do_enq;
    logic                 do_deq;

    assign not_empty  = (count != '0);
    // Full depends only on registered count so stall never sees deq_ready.
    assign queue_full = (count == CNT_W'(DEPTH));
    assign do_deq     = not_empty && deq_ready && !flush;

`ifdef INSTR_QUEUE_BYPASS_EN
    logic bypass;

    assign bypass = !not_empty && enq_valid && !flush;
    // A bypassed entry taken by the consumer never touches storage.
    assign do_enq = enq_valid && !queue_full && !flush && !(bypass && deq_ready);

    always_comb begin
        deq_valid = not_empty || bypass;
        deq_data  = '0;
        if (not_empty) begin
            deq_data = mem[head];
        end else if (bypass) begin
            deq_data = enq_data;
        end
    end
`else
    assign do_enq = enq_valid && !queue_full && !flush;

    always_comb begin
        deq_valid = not_empty;
        deq_data  = '0;
        if (not_empty) begin
            deq_data = mem[head];
        end
    end
`endif

    // Storage is not reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[tail] <= enq_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_deq) begin
                head <= head + PTR_W'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Table-driven check of instr_queue at DEPTH=4, plus async-reset sequences.
module tb_instr_queue;
    import instr_queue_pkg::*;

`ifdef INSTR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [PIPE_IN_W-1:0] data_t;

    typedef struct {
        logic  flush;
        logic  enq_valid;
        data_t enq_data;
        logic  deq_ready;
        int    exp_count;
        logic  exp_full;
        logic  exp_dv;
        data_t exp_dd;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    data_t       enq_data;
    logic        queue_full;
    logic        deq_valid;
    data_t       deq_data;
    logic        deq_ready;
    logic [2:0]  count;

    int checks;
    int errors;
    vec_t vecs[$];

    instr_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .enq_valid  (enq_valid),
        .enq_data   (enq_data),
        .queue_full (queue_full),
        .deq_valid  (deq_valid),
        .deq_data   (deq_data),
        .deq_ready  (deq_ready),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic fl, input logic ev, input data_t ed, input logic dr,
                       input int ec, input logic ef, input logic edv, input data_t edd);
        vec_t v;
        v.flush = fl; v.enq_valid = ev; v.enq_data = ed; v.deq_ready = dr;
        v.exp_count = ec; v.exp_full = ef; v.exp_dv = edv; v.exp_dd = edd;
        vecs.push_back(v);
    endtask

    task automatic check_outs(input string name, input int ec, input logic ef,
                              input logic edv, input data_t edd);
        checks += 4;
        if (int'(count) != ec) begin
            errors++;
            $display("FAIL %s count: got %0d expected %0d", name, count, ec);
        end
        if (queue_full !== ef) begin
            errors++;
            $display("FAIL %s queue_full: got %b expected %b", name, queue_full, ef);
        end
        if (deq_valid !== edv) begin
            errors++;
            $display("FAIL %s deq_valid: got %b expected %b", name, deq_valid, edv);
        end
        if (deq_data !== edd) begin
            errors++;
            $display("FAIL %s deq_data: got %h expected %h", name, deq_data, edd);
        end
    endtask

    task automatic drive(input logic fl, input logic ev, input data_t ed, input logic dr);
        flush = fl; enq_valid = ev; enq_data = ed; deq_ready = dr;
    endtask

    initial begin
        data_t a, b, c, d, e, f, g, h, i_, j, k, l, m, n, p, q, x, w0, w1, w2, w3;
        a = 64'hA;  b = 64'hB;  c = 64'hC;  d = 64'hD;  e = 64'hE;
        f = 64'hF;  g = 64'h10; h = 64'h11; i_ = 64'h12; j = 64'h13;
        k = 64'h14; l = 64'h15; m = 64'h16; n = 64'h17; p = 64'h18;
        q = 64'h19; x = 64'h1A;
        w0 = 64'h20; w1 = 64'h21; w2 = 64'h22; w3 = 64'h23;
        checks = 0;
        errors = 0;

        // Expected outputs seen in each row's cycle, before that row's clock edge.
        // Fill to full, drop E while full.
        add(0, 1, a, 0, 0, 0, BYP, BYP ? a : '0);
        add(0, 1, b, 0, 1, 0, 1, a);
        add(0, 1, c, 0, 2, 0, 1, a);
        add(0, 1, d, 0, 3, 0, 1, a);
        add(0, 1, e, 0, 4, 1, 1, a);
        add(0, 1, e, 0, 4, 1, 1, a);
        // Dequeue from full with E pending: E blocked, then accepted on wrap.
        add(0, 1, e, 1, 4, 1, 1, a);
        add(0, 1, e, 0, 3, 0, 1, b);
        add(0, 0, '0, 1, 4, 1, 1, b);
        add(0, 0, '0, 1, 3, 0, 1, c);
        add(0, 0, '0, 1, 2, 0, 1, d);
        add(0, 0, '0, 1, 1, 0, 1, e);
        // Empty with deq_ready: no underflow.
        add(0, 0, '0, 1, 0, 0, 0, '0);
        add(0, 0, '0, 1, 0, 0, 0, '0);
        // Two entries, then six simultaneous enq/deq cycles.
        add(0, 1, f, 0, 0, 0, BYP, BYP ? f : '0);
        add(0, 1, g, 0, 1, 0, 1, f);
        add(0, 1, h, 1, 2, 0, 1, f);
        add(0, 1, i_, 1, 2, 0, 1, g);
        add(0, 1, j, 1, 2, 0, 1, h);
        add(0, 1, k, 1, 2, 0, 1, i_);
        add(0, 1, l, 1, 2, 0, 1, j);
        add(0, 1, m, 1, 2, 0, 1, k);
        // Three entries, flush with concurrent enq and deq.
        add(0, 1, n, 0, 2, 0, 1, l);
        add(1, 1, p, 1, 3, 0, 1, l);
        add(0, 0, '0, 0, 0, 0, 0, '0);
        add(0, 1, q, 0, 0, 0, BYP, BYP ? q : '0);
        add(0, 0, '0, 0, 1, 0, 1, q);
        add(0, 0, '0, 1, 1, 0, 1, q);
        add(0, 0, '0, 0, 0, 0, 0, '0);
        // Empty queue, enqueue X with deq_ready: bypass or one-cycle latency.
        add(0, 1, x, 1, 0, 0, BYP, BYP ? x : '0);
        add(0, 0, '0, 0, BYP ? 0 : 1, 0, !BYP, BYP ? '0 : x);
        add(0, 0, '0, 1, BYP ? 0 : 1, 0, !BYP, BYP ? '0 : x);
        add(0, 0, '0, 0, 0, 0, 0, '0);
        // Flush while full.
        add(0, 1, w0, 0, 0, 0, BYP, BYP ? w0 : '0);
        add(0, 1, w1, 0, 1, 0, 1, w0);
        add(0, 1, w2, 0, 2, 0, 1, w0);
        add(0, 1, w3, 0, 3, 0, 1, w0);
        add(1, 1, a, 0, 4, 1, 1, w0);
        add(0, 0, '0, 0, 0, 0, 0, '0);

        drive(0, 0, '0, 0);
        reset = 1'b1;
        #1;
        check_outs("reset_initial", 0, 0, 0, '0);
        @(negedge clk);
        reset = 1'b0;

        for (int vi = 0; vi < vecs.size(); vi++) begin
            @(negedge clk);
            drive(vecs[vi].flush, vecs[vi].enq_valid, vecs[vi].enq_data, vecs[vi].deq_ready);
            #1;
            check_outs($sformatf("vec%0d", vi), vecs[vi].exp_count, vecs[vi].exp_full,
                       vecs[vi].exp_dv, vecs[vi].exp_dd);
        end

        // Reset asserted between edges on a busy queue takes effect immediately.
        @(negedge clk);
        drive(0, 1, b, 0);
        @(negedge clk);
        drive(0, 1, c, 0);
        @(negedge clk);
        drive(0, 0, '0, 0);
        #1;
        check_outs("pre_reset", 2, 0, 1, b);
        #2;
        reset = 1'b1;
        #1;
        check_outs("reset_midcycle", 0, 0, 0, '0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outs("after_reset", 0, 0, 0, '0);

        // Full queue hit by async reset.
        for (int wi = 0; wi < 4; wi++) begin
            @(negedge clk);
            drive(0, 1, data_t'(64'h30 + wi), 0);
        end
        @(negedge clk);
        drive(0, 0, '0, 0);
        #1;
        check_outs("full_before_reset", 4, 1, 1, 64'h30);
        reset = 1'b1;
        #1;
        check_outs("full_reset", 0, 0, 0, '0);
        @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
